// File: rtl/spu_pipe_pkg.sv
// Shared SPU pipeline definitions: packed forwarding-bus layout, datapath
// widths, bubble instruction ids, execution-unit encodings and the even-pipe
// operand record.
package spu_pipe_pkg;

  localparam int DATA_W     = 128;
  localparam int REG_ADDR_W = 7;
  localparam int INSTR_ID_W = 7;
  localparam int UNIT_W     = 3;
  localparam int LAT_W      = 4;

  // Forwarding bus: {RegWr, latency, dst, result, unit}
  localparam int FWD_W        = 143;
  localparam int FWD_UNIT_LSB = 0;
  localparam int FWD_UNIT_MSB = 2;
  localparam int FWD_RES_LSB  = 3;
  localparam int FWD_RES_MSB  = 130;
  localparam int FWD_DST_LSB  = 131;
  localparam int FWD_DST_MSB  = 137;
  localparam int FWD_LAT_LSB  = 138;
  localparam int FWD_LAT_MSB  = 141;
  localparam int FWD_WR_BIT   = 142;

  localparam logic [INSTR_ID_W-1:0] EVEN_NOP_ID = 7'd86;
  localparam logic [INSTR_ID_W-1:0] ODD_NOP_ID  = 7'd87;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_NONE             = 3'd0,
    UNIT_SIMPLE_FIXED_1   = 3'd1,
    UNIT_SIMPLE_FIXED_2   = 3'd2,
    UNIT_SINGLE_PRECISION = 3'd3,
    UNIT_BYTE             = 3'd4,
    UNIT_PERMUTE          = 3'd5,
    UNIT_LOCAL_STORE      = 3'd6,
    UNIT_BRANCH           = 3'd7
  } unit_id_e;

  // Everything the even pipe receives from the operand stage
  typedef struct packed {
    logic [31:0]             full_instr;
    logic [INSTR_ID_W-1:0]   instr_id;
    logic [REG_ADDR_W-1:0]   reg_dst;
    logic [UNIT_W-1:0]       unit_id;
    logic [LAT_W-1:0]        latency;
    logic                    reg_wr;
    logic [6:0]              imme7;
    logic [9:0]              imme10;
    logic [15:0]             imme16;
    logic [17:0]             imme18;
    logic [DATA_W-1:0]       ra_data;
    logic [DATA_W-1:0]       rb_data;
    logic [DATA_W-1:0]       rc_data;
  } even_instr_t;

endpackage

// File: rtl/even_fwd_select.sv
// Per-source operand selection: finds the youngest in-flight producer of one
// source register and reports either its result or a not-ready hazard.
// Optional feature: EVEN_WB_BYPASS_EN makes a write-back match forwardable.
module even_fwd_select
  import spu_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  src_use,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic [REG_ADDR_W-1:0] s1_dst,
  input  logic                  s1_wr,
  input  logic [LAT_W-1:0]      s1_lat,
  input  logic [FWD_W-1:0]      fwd [2:7],
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  wb_en,
  output logic [DATA_W-1:0]     data,
  output logic                  hazard
);

`ifdef EVEN_WB_BYPASS_EN
  localparam logic WB_READY = 1'b1;
`else
  localparam logic WB_READY = 1'b0;
`endif

  logic              hit;
  logic              rdy;
  logic [DATA_W-1:0] sel;
  logic              unused_unit_bits;

  // Walk producers oldest to youngest so the youngest match overrides.
  // The operand register holds no result, so a latency-0 stage-1 producer
  // is taken as already architectural and the register-file value stands.
  always_comb begin
    hit = 1'b0;
    rdy = 1'b0;
    sel = rf_data;
    if (wb_en && (wb_addr == src_addr)) begin
      hit = 1'b1;
      rdy = WB_READY;
      sel = wb_data;
    end
    for (int k = 7; k >= 2; k--) begin
      if (fwd[k][FWD_WR_BIT] && (fwd[k][FWD_DST_MSB:FWD_DST_LSB] == src_addr)) begin
        hit = 1'b1;
        rdy = (int'(fwd[k][FWD_LAT_MSB:FWD_LAT_LSB]) <= k);
        sel = fwd[k][FWD_RES_MSB:FWD_RES_LSB];
      end
    end
    if (s1_wr && (s1_dst == src_addr)) begin
      hit = 1'b1;
      rdy = (s1_lat == '0);
      sel = rf_data;
    end
  end

  assign data   = (src_use && hit) ? sel : rf_data;
  assign hazard = src_use && hit && !rdy;

  assign unused_unit_bits = ^{fwd[2][FWD_UNIT_MSB:FWD_UNIT_LSB], fwd[3][FWD_UNIT_MSB:FWD_UNIT_LSB],
                              fwd[4][FWD_UNIT_MSB:FWD_UNIT_LSB], fwd[5][FWD_UNIT_MSB:FWD_UNIT_LSB],
                              fwd[6][FWD_UNIT_MSB:FWD_UNIT_LSB], fwd[7][FWD_UNIT_MSB:FWD_UNIT_LSB]};

endmodule

// File: rtl/even_operand_stage.sv
// Even-pipe operand stage: resolves ra/rb/rc through the forwarding network,
// stalls on not-ready producers, and registers the issued instruction or a
// bubble. Optional feature: EVEN_WB_BYPASS_EN (write-back forwarding).
module even_operand_stage
  import spu_pipe_pkg::*;
#(
  parameter int                    STALL_CNT_W = 16,
  parameter logic [INSTR_ID_W-1:0] NOP_ID      = EVEN_NOP_ID
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_full_instr,
  input  logic [INSTR_ID_W-1:0]  in_instr_id,
  input  logic [REG_ADDR_W-1:0]  in_reg_dst,
  input  logic [UNIT_W-1:0]      in_unit_id,
  input  logic [LAT_W-1:0]       in_latency,
  input  logic                   in_reg_wr,
  input  logic [6:0]             in_imme7,
  input  logic [9:0]             in_imme10,
  input  logic [15:0]            in_imme16,
  input  logic [17:0]            in_imme18,
  input  logic [REG_ADDR_W-1:0]  in_ra_addr,
  input  logic [REG_ADDR_W-1:0]  in_rb_addr,
  input  logic [REG_ADDR_W-1:0]  in_rc_addr,
  input  logic                   in_use_ra,
  input  logic                   in_use_rb,
  input  logic                   in_use_rc,
  input  logic [DATA_W-1:0]      rf_ra_data,
  input  logic [DATA_W-1:0]      rf_rb_data,
  input  logic [DATA_W-1:0]      rf_rc_data,
  input  logic [FWD_W-1:0]       fwd_2stage,
  input  logic [FWD_W-1:0]       fwd_3stage,
  input  logic [FWD_W-1:0]       fwd_4stage,
  input  logic [FWD_W-1:0]       fwd_5stage,
  input  logic [FWD_W-1:0]       fwd_6stage,
  input  logic [FWD_W-1:0]       fwd_7stage,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   wb_en,
  input  logic                   flush,
  output logic [31:0]            out_full_instr,
  output logic [INSTR_ID_W-1:0]  out_instr_id,
  output logic [REG_ADDR_W-1:0]  out_reg_dst,
  output logic [UNIT_W-1:0]      out_unit_id,
  output logic [LAT_W-1:0]       out_latency,
  output logic                   out_reg_wr,
  output logic [6:0]             out_imme7,
  output logic [9:0]             out_imme10,
  output logic [15:0]            out_imme16,
  output logic [17:0]            out_imme18,
  output logic [DATA_W-1:0]      out_ra_data,
  output logic [DATA_W-1:0]      out_rb_data,
  output logic [DATA_W-1:0]      out_rc_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam even_instr_t BUBBLE = '{
    full_instr: '0, instr_id: NOP_ID, reg_dst: '0, unit_id: UNIT_NONE,
    latency: '0, reg_wr: 1'b0, imme7: '0, imme10: '0, imme16: '0,
    imme18: '0, ra_data: '0, rb_data: '0, rc_data: '0
  };

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [FWD_W-1:0]  fwd_bus [2:7];
  logic [DATA_W-1:0] ra_data, rb_data, rc_data;
  logic              ra_haz, rb_haz, rc_haz;
  logic              hazard;
  logic              fire;
  even_instr_t       in_pkt;
  even_instr_t       out_pkt;

  assign fwd_bus[2] = fwd_2stage;
  assign fwd_bus[3] = fwd_3stage;
  assign fwd_bus[4] = fwd_4stage;
  assign fwd_bus[5] = fwd_5stage;
  assign fwd_bus[6] = fwd_6stage;
  assign fwd_bus[7] = fwd_7stage;

  even_fwd_select u_fwd_ra (
    .src_addr(in_ra_addr), .src_use(in_use_ra), .rf_data(rf_ra_data),
    .s1_dst(out_pkt.reg_dst), .s1_wr(out_pkt.reg_wr), .s1_lat(out_pkt.latency),
    .fwd(fwd_bus), .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en),
    .data(ra_data), .hazard(ra_haz)
  );

  even_fwd_select u_fwd_rb (
    .src_addr(in_rb_addr), .src_use(in_use_rb), .rf_data(rf_rb_data),
    .s1_dst(out_pkt.reg_dst), .s1_wr(out_pkt.reg_wr), .s1_lat(out_pkt.latency),
    .fwd(fwd_bus), .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en),
    .data(rb_data), .hazard(rb_haz)
  );

  even_fwd_select u_fwd_rc (
    .src_addr(in_rc_addr), .src_use(in_use_rc), .rf_data(rf_rc_data),
    .s1_dst(out_pkt.reg_dst), .s1_wr(out_pkt.reg_wr), .s1_lat(out_pkt.latency),
    .fwd(fwd_bus), .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en),
    .data(rc_data), .hazard(rc_haz)
  );

  assign hazard   = in_valid && (ra_haz || rb_haz || rc_haz);
  assign in_ready = !hazard && !flush;
  assign fire     = in_valid && in_ready;

  assign in_pkt = '{
    full_instr: in_full_instr, instr_id: in_instr_id, reg_dst: in_reg_dst,
    unit_id: in_unit_id, latency: in_latency, reg_wr: in_reg_wr,
    imme7: in_imme7, imme10: in_imme10, imme16: in_imme16, imme18: in_imme18,
    ra_data: ra_data, rb_data: rb_data, rc_data: rc_data
  };

  // Operand register: issue the instruction on a handshake, otherwise a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pkt <= BUBBLE;
    end else if (fire) begin
      out_pkt <= in_pkt;
    end else begin
      out_pkt <= BUBBLE;
    end
  end

  // Saturating count of cycles lost to operand hazards (flush cycles excluded)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hazard && !flush) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign out_full_instr = out_pkt.full_instr;
  assign out_instr_id   = out_pkt.instr_id;
  assign out_reg_dst    = out_pkt.reg_dst;
  assign out_unit_id    = out_pkt.unit_id;
  assign out_latency    = out_pkt.latency;
  assign out_reg_wr     = out_pkt.reg_wr;
  assign out_imme7      = out_pkt.imme7;
  assign out_imme10     = out_pkt.imme10;
  assign out_imme16     = out_pkt.imme16;
  assign out_imme18     = out_pkt.imme18;
  assign out_ra_data    = out_pkt.ra_data;
  assign out_rb_data    = out_pkt.rb_data;
  assign out_rc_data    = out_pkt.rc_data;

endmodule
